bram_rd_sched: RTL and testbench
================================

// Module: bram_rd_sched
// PURPOSE
// - Shares the single read port of the multi-stream BRAM buffer between NREQ requesters.
// - Each accepted request is one cache-line read: a burst of BEATS reads at offsets 0..BEATS-1,
//   all to the same {channel, stream, line}.
// - Round-robin arbitration between requesters; a tag FIFO routes each returned beat to its owner.
// - Sits between the stream read engines and the BRAM read/return interface.
// PARAMETERS
// - NREQ            4   number of requesters
// - DATA_WIDTH      64  BRAM element width; a returned beat is 2*DATA_WIDTH
// - channels_width  1   channel select width
// - l1_nstrms_width 4   stream index width
// - l1_ncl_width    4   cache-line index width
// - WAYS_WIDTH      3   offset width
// - BEATS           8   reads per request, 2..2**WAYS_WIDTH
// - TAG_DEPTH       8   max outstanding reads; power of 2, must be >= BRAM credit count (6)
// PORTS
// - clk      in   1                     clock
// - reset_n  in   1                     synchronous reset, active low
// - req_v    in   NREQ                  request valid, one bit per requester
// - req_r    out  NREQ                  request accepted (one-hot, one cycle)
// - req_ch   in   NREQ*channels_width   channel, packed, requester 0 in the LSBs
// - req_st   in   NREQ*l1_nstrms_width  stream, packed
// - req_cl   in   NREQ*l1_ncl_width     cache line, packed
// - m_v      out  1                     BRAM read valid
// - m_r      in   1                     BRAM read ready
// - m_ra_ch  out  channels_width        read channel
// - m_ra_st  out  l1_nstrms_width       read stream
// - m_ra_cl  out  l1_ncl_width          read line
// - m_ra_of  out  WAYS_WIDTH            read offset
// - s_v      in   1                     BRAM return valid
// - s_r      out  1                     BRAM return ready
// - s_rd     in   2*DATA_WIDTH          BRAM return data
// - rsp_v    out  NREQ                  response valid, one-hot to the owner
// - rsp_r    in   NREQ                  response ready per requester
// - rsp_d    out  2*DATA_WIDTH          response data (s_rd passthrough)
// - rsp_last out  1                     last beat of a request
// - err      out  1                     sticky: s_v seen while the tag FIFO is empty
// BEHAVIOUR
// - Reset (reset_n=0 at posedge clk):
//   - state=IDLE, rr_ptr=0, beat=0, tag FIFO empty, err=0.
//   - req_r, m_v, rsp_v and s_r all read 0.
// - Reset mid-burst drops the burst and all outstanding tags. The BRAM path is reset with it.
// - FSM IDLE:
//   - Grant g is the first set req_v bit searching from rr_ptr upward, with wrap.
//   - req_r[g]=1 in the same cycle (combinational); latch ch/st/cl of g; rr_ptr<=g+1 mod NREQ.
//   - beat<=0; go to BURST. No req_v bit set: stay in IDLE.
// - FSM BURST:
//   - m_v = !tag_full. m_ra_* = latched fields; m_ra_of = beat.
//   - On m_v&m_r: push tag {g, beat==BEATS-1}; beat<=beat+1.
//   - On the BEATS-1 issue, go to IDLE. This gives one bubble cycle between bursts.
//   - m_ra_* hold stable while m_v&!m_r.
// - req_r is never asserted in BURST. The first m_v comes the cycle after req_r.
// - Tag FIFO: depth TAG_DEPTH, registered full/empty.
//   - Push and pop in the same cycle when full are allowed; occupancy is unchanged.
//   - Full: m_v=0 until a pop. Empty: s_r=1 (drain) and err<=1 if s_v.
// - Return path, tag FIFO non-empty, head tag {h, last}:
//   - rsp_v = s_v<<h; s_r = rsp_r[h]; rsp_last = last.
//   - Pop on s_v&s_r. Zero-latency passthrough; return order = issue order.
// - Responses to a requester arrive in request order, BEATS beats each, and never interleave
//   with another requester's beats.
// - A requester with req_v held gets at most one grant per NREQ grants (fairness).
// CONFIGURATION
// - BRAM_RD_SCHED_PRIO_EN defined:
//   - Requester 0 is high priority. It is granted in IDLE whenever req_v[0]=1.
//   - rr_ptr is left unchanged by a requester-0 grant.
//   - Round-robin applies only to requesters 1..NREQ-1 when req_v[0]=0.
// - BRAM_RD_SCHED_PRIO_EN undefined: pure round-robin over all NREQ requesters.
// TESTING
// - Single request req_v=4'b0010, st=3, cl=5, m_r=1:
//   -> req_r=0010 one cycle; 8 m_v beats with of=0..7.
//   -> 8 rsp_v=0010 beats; rsp_last on the 8th only.
// - req_v=4'b1111 held, m_r=1 -> grant order 0,1,2,3,0; 8 beats each; 1 idle cycle between bursts.
// - m_r=0 for 5 cycles mid-burst at of=3 -> m_ra_* held at of=3; no tag pushed; resumes at of=3.
// - s_v stalled, 2 requests issued -> m_v drops after 8 issues (TAG_DEPTH full).
//   -> resumes one issue per return pop.
// - rsp_r[1]=0 with head tag owner 1 -> s_r=0; data held; rsp_v=0010 until rsp_r[1]=1.
// - reset_n=0 at of=4 -> next cycle all outputs 0, FIFO empty.
//   -> a later s_v with no request outstanding sets err=1.
// - PRIO_EN: req_v=1111 held -> grants 0,0,0...; with req_v[0]=0 -> 1,2,3,1.

Source files
------------

// File: rtl/bram_rd_sched.sv
// Read-port scheduler: round-robin grants of BEATS-long bursts to the shared BRAM read port,
// with a tag FIFO steering returned beats to their owners. Optional macro: BRAM_RD_SCHED_PRIO_EN.
module bram_rd_sched #(
    parameter int NREQ            = 4,
    parameter int DATA_WIDTH      = 64,
    parameter int channels_width  = 1,
    parameter int l1_nstrms_width = 4,
    parameter int l1_ncl_width    = 4,
    parameter int WAYS_WIDTH      = 3,
    parameter int BEATS           = 8,
    parameter int TAG_DEPTH       = 8
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NREQ-1:0]                   req_v,
    output logic [NREQ-1:0]                   req_r,
    input  logic [NREQ*channels_width-1:0]    req_ch,
    input  logic [NREQ*l1_nstrms_width-1:0]   req_st,
    input  logic [NREQ*l1_ncl_width-1:0]      req_cl,
    output logic                              m_v,
    input  logic                              m_r,
    output logic [channels_width-1:0]         m_ra_ch,
    output logic [l1_nstrms_width-1:0]        m_ra_st,
    output logic [l1_ncl_width-1:0]           m_ra_cl,
    output logic [WAYS_WIDTH-1:0]             m_ra_of,
    input  logic                              s_v,
    output logic                              s_r,
    input  logic [2*DATA_WIDTH-1:0]           s_rd,
    output logic [NREQ-1:0]                   rsp_v,
    input  logic [NREQ-1:0]                   rsp_r,
    output logic [2*DATA_WIDTH-1:0]           rsp_d,
    output logic                              rsp_last,
    output logic                              err
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]                 state_q, state_d;
    logic [GW-1:0]              rr_q, rr_d;
    logic [WAYS_WIDTH-1:0]      beat_q, beat_d;
    logic [GW-1:0]              owner_q, owner_d;
    logic [channels_width-1:0]  ch_q, ch_d;
    logic [l1_nstrms_width-1:0] st_q, st_d;
    logic [l1_ncl_width-1:0]    cl_q, cl_d;
    logic                       err_q, err_d;

    logic [GW:0]                tag_mem_q [TAG_DEPTH];
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic                       full_q, full_d;
    logic                       empty_q, empty_d;

    logic [NREQ-1:0]            rr_req;
    logic                       prio_hit;
    logic                       gnt_vld;
    logic [GW-1:0]              gnt_idx;
    logic [NREQ-1:0]            req_r_raw;
    logic                       m_v_raw;
    logic                       push, pop;
    logic [GW:0]                tag_wdata;
    logic [GW:0]                head;
    logic [GW-1:0]              head_own;

`ifdef BRAM_RD_SCHED_PRIO_EN
    // Requester 0 bypasses the rotation; the pointer only cycles over 1..NREQ-1.
    assign rr_req   = req_v & {{(NREQ-1){1'b1}}, 1'b0};
    assign prio_hit = req_v[0];
`else
    assign rr_req   = req_v;
    assign prio_hit = 1'b0;
`endif

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (prio_hit) begin
            gnt_vld = 1'b1;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (!gnt_vld && rr_req[(int'(rr_q) + i) % NREQ]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = GW'((int'(rr_q) + i) % NREQ);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        beat_d    = beat_q;
        owner_d   = owner_q;
        ch_d      = ch_q;
        st_d      = st_q;
        cl_d      = cl_q;
        req_r_raw = '0;
        m_v_raw   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    req_r_raw = NREQ'(1) << gnt_idx;
                    owner_d   = gnt_idx;
                    ch_d      = req_ch[gnt_idx*channels_width +: channels_width];
                    st_d      = req_st[gnt_idx*l1_nstrms_width +: l1_nstrms_width];
                    cl_d      = req_cl[gnt_idx*l1_ncl_width +: l1_ncl_width];
                    beat_d    = '0;
                    state_d   = ST_BURST;
                    if (!prio_hit) begin
                        rr_d = (gnt_idx == GW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
            end
            ST_BURST: begin
                m_v_raw = !full_q;
                if (!full_q && m_r) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == WAYS_WIDTH'(BEATS-1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, independent of stale state.
    assign req_r     = reset_n ? req_r_raw : '0;
    assign m_v       = reset_n & m_v_raw;
    assign push      = m_v & m_r;
    assign tag_wdata = {owner_q, beat_q == WAYS_WIDTH'(BEATS-1)};

    assign m_ra_ch = ch_q;
    assign m_ra_st = st_q;
    assign m_ra_cl = cl_q;
    assign m_ra_of = beat_q;

    assign head     = tag_mem_q[rd_ptr_q];
    assign head_own = head[GW:1];
    assign rsp_d    = s_rd;

    always_comb begin
        rsp_v    = '0;
        s_r      = 1'b0;
        rsp_last = 1'b0;
        pop      = 1'b0;
        if (reset_n) begin
            if (empty_q) begin
                s_r = 1'b1;
            end else begin
                s_r      = rsp_r[head_own];
                rsp_v    = s_v ? (NREQ'(1) << head_own) : '0;
                rsp_last = head[0];
                pop      = s_v & rsp_r[head_own];
            end
        end
    end

    assign err = err_q;

    always_comb begin
        err_d    = err_q | (empty_q & s_v);
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
        full_d  = (cnt_d == CW'(TAG_DEPTH));
        empty_d = (cnt_d == '0);
    end

    // Control state: synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            beat_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            beat_q   <= beat_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Burst fields and tag storage carry data only; no reset needed.
    always_ff @(posedge clk) begin
        owner_q <= owner_d;
        ch_q    <= ch_d;
        st_q    <= st_d;
        cl_q    <= cl_d;
        if (push) begin
            tag_mem_q[wr_ptr_q] <= tag_wdata;
        end
    end

endmodule

// File: tb/tb_bram_rd_sched.sv
// Bench for bram_rd_sched: queue-based transaction model plus grant table and directed corners.
module tb_bram_rd_sched;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int CHW  = 1;
    localparam int STW  = 4;
    localparam int CLW  = 4;
    localparam int WW   = 3;
    localparam int BEATS = 8;
    localparam int TAG_DEPTH = 8;

    logic                 clk;
    logic                 reset_n;
    logic [NREQ-1:0]      req_v, req_r;
    logic [NREQ*CHW-1:0]  req_ch;
    logic [NREQ*STW-1:0]  req_st;
    logic [NREQ*CLW-1:0]  req_cl;
    logic                 m_v, m_r;
    logic [CHW-1:0]       m_ra_ch;
    logic [STW-1:0]       m_ra_st;
    logic [CLW-1:0]       m_ra_cl;
    logic [WW-1:0]        m_ra_of;
    logic                 s_v, s_r;
    logic [2*DW-1:0]      s_rd, rsp_d;
    logic [NREQ-1:0]      rsp_v, rsp_r;
    logic                 rsp_last, err;

    bram_rd_sched #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .channels_width(CHW), .l1_nstrms_width(STW),
        .l1_ncl_width(CLW), .WAYS_WIDTH(WW), .BEATS(BEATS), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_v(req_v), .req_r(req_r), .req_ch(req_ch),
        .req_st(req_st), .req_cl(req_cl), .m_v(m_v), .m_r(m_r), .m_ra_ch(m_ra_ch),
        .m_ra_st(m_ra_st), .m_ra_cl(m_ra_cl), .m_ra_of(m_ra_of), .s_v(s_v), .s_r(s_r),
        .s_rd(s_rd), .rsp_v(rsp_v), .rsp_r(rsp_r), .rsp_d(rsp_d), .rsp_last(rsp_last),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             own;
        logic [CHW-1:0] ch;
        logic [STW-1:0] st;
        logic [CLW-1:0] cl;
        logic [WW-1:0]  of;
    } iss_t;
    typedef struct {
        int own;
        bit last;
    } ret_t;
    typedef struct {
        logic [NREQ-1:0] req_v;
        logic [NREQ-1:0] exp_r;
    } vec_t;

    iss_t issq[$];
    ret_t retq[$];
    int   gnt_log[$];
    int   gnt_cyc[$];
    vec_t tbl[8];

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rr_m = 0;
    bit   err_exp = 0;
    bit   gnt_flag = 0;
    logic [NREQ-1:0] gnt_act = '0;
    int   iss_cnt = 0, rsp_cnt = 0, last_cnt = 0;
    bit   auto_sv = 0;
    int   sv_pct = 100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        n_err++;
        $display("FAIL %s: bound expired at cycle %0d", nm, cyc);
    endtask

    // Round-robin rule: first requesting index at or after rr_m, wrapping.
    function automatic int pred_grant(input logic [NREQ-1:0] rv);
`ifdef BRAM_RD_SCHED_PRIO_EN
        if (rv[0]) return 0;
`endif
        for (int i = 0; i < NREQ; i++) begin
            int k;
            k = (rr_m + i) % NREQ;
`ifdef BRAM_RD_SCHED_PRIO_EN
            if (k == 0) continue;
`endif
            if (rv[k]) return k;
        end
        return -1;
    endfunction

    int   occ_i, occ_r, g, h;
    bit   lst, exp_mv;
    logic [NREQ-1:0] exp_rr;
    iss_t e;

    always @(negedge clk) begin
        chk("err", err, err_exp);
        if (!reset_n) begin
            chk("rst_req_r", req_r, 0);
            chk("rst_m_v", m_v, 0);
            chk("rst_rsp_v", rsp_v, 0);
            chk("rst_s_r", s_r, 0);
            issq.delete();
            retq.delete();
            rr_m = 0;
            err_exp = 0;
        end else begin
            occ_i = issq.size();
            occ_r = retq.size();
            if (occ_r == 0) begin
                chk("s_r_drain", s_r, 1);
                chk("rsp_v_idle", rsp_v, 0);
                if (s_v) err_exp = 1;
            end else begin
                h   = retq[0].own;
                lst = retq[0].last;
                chk("rsp_v", rsp_v, s_v ? (128'(1) << h) : 128'(0));
                chk("s_r", s_r, rsp_r[h]);
                chk("rsp_last", rsp_last, lst);
                if (s_v) chk("rsp_d", rsp_d, s_rd);
                if (s_v && rsp_r[h]) begin
                    void'(retq.pop_front());
                    rsp_cnt++;
                    if (lst) last_cnt++;
                end
            end
            exp_mv = (occ_i > 0) && (occ_r < TAG_DEPTH);
            chk("m_v", m_v, exp_mv);
            if (m_v && m_r && occ_i > 0) begin
                e = issq.pop_front();
                chk("m_ra_ch", m_ra_ch, e.ch);
                chk("m_ra_st", m_ra_st, e.st);
                chk("m_ra_cl", m_ra_cl, e.cl);
                chk("m_ra_of", m_ra_of, e.of);
                retq.push_back('{own: e.own, last: (e.of == WW'(BEATS-1))});
                iss_cnt++;
            end
            g = pred_grant(req_v);
            exp_rr = (occ_i == 0 && g >= 0) ? (NREQ'(1) << g) : '0;
            chk("req_r", req_r, exp_rr);
            if (req_r != 0 || exp_rr != 0) begin
                gnt_flag = 1;
                gnt_act  = req_r;
            end
            if (exp_rr != 0) begin
                for (int b = 0; b < BEATS; b++) begin
                    issq.push_back('{own: g, ch: req_ch[g*CHW +: CHW], st: req_st[g*STW +: STW],
                                     cl: req_cl[g*CLW +: CLW], of: WW'(b)});
                end
                gnt_log.push_back(g);
                gnt_cyc.push_back(cyc);
`ifdef BRAM_RD_SCHED_PRIO_EN
                if (g != 0) rr_m = (g + 1) % NREQ;
`else
                rr_m = (g + 1) % NREQ;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (auto_sv) begin
            s_v  = (retq.size() > 0) && ($urandom_range(99) < sv_pct);
            s_rd = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    task automatic wait_grant(input int maxc, output logic [NREQ-1:0] got);
        got = '0;
        gnt_flag = 0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (gnt_flag) begin
                got = gnt_act;
                gnt_flag = 0;
                return;
            end
        end
        timeout("grant_wait");
    endtask

    task automatic wait_idle(input int maxc);
        for (int i = 0; i < maxc; i++) begin
            if (issq.size() == 0 && retq.size() == 0) return;
            step();
        end
        timeout("idle_wait");
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] got;
        int i0, r0, l0;

`ifdef BRAM_RD_SCHED_PRIO_EN
        tbl[0] = '{4'b0010, 4'b0010}; tbl[1] = '{4'b1111, 4'b0001};
        tbl[2] = '{4'b1111, 4'b0001}; tbl[3] = '{4'b1111, 4'b0001};
        tbl[4] = '{4'b0001, 4'b0001}; tbl[5] = '{4'b1001, 4'b0001};
        tbl[6] = '{4'b0110, 4'b0100}; tbl[7] = '{4'b0010, 4'b0010};
`else
        tbl[0] = '{4'b0010, 4'b0010}; tbl[1] = '{4'b1111, 4'b0100};
        tbl[2] = '{4'b1111, 4'b1000}; tbl[3] = '{4'b1111, 4'b0001};
        tbl[4] = '{4'b0001, 4'b0001}; tbl[5] = '{4'b1001, 4'b1000};
        tbl[6] = '{4'b0110, 4'b0010}; tbl[7] = '{4'b0010, 4'b0010};
`endif

        reset_n = 1'b0; req_v = '0; req_ch = '0; req_st = '0; req_cl = '0;
        m_r = 1'b0; s_v = 1'b0; s_rd = '0; rsp_r = '0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_err", err, 0);
        chk("reset_m_v", m_v, 0);
        reset_n = 1'b1;
        step();

        // Grant table, starting from a fresh rotation pointer.
        auto_sv = 1; sv_pct = 100; m_r = 1'b1; rsp_r = '1;
        for (int k = 0; k < 8; k++) begin
            req_ch = NREQ'($urandom); req_st = 16'($urandom); req_cl = 16'($urandom);
            if (k == 0) begin
                req_st[STW +: STW] = 4'd3;
                req_cl[CLW +: CLW] = 4'd5;
            end
            i0 = iss_cnt; r0 = rsp_cnt; l0 = last_cnt;
            req_v = tbl[k].req_v;
            wait_grant(30, got);
            req_v = '0;
            chk("tbl_grant", got, tbl[k].exp_r);
            wait_idle(80);
            chk("tbl_issues", iss_cnt - i0, BEATS);
            chk("tbl_rsps", rsp_cnt - r0, BEATS);
            chk("tbl_lasts", last_cnt - l0, 1);
        end

        // All requesters held: grant order and one bubble between bursts.
        do_reset(2);
        gnt_log.delete(); gnt_cyc.delete();
        req_v = '1;
        for (int i = 0; i < 120 && gnt_log.size() < 5; i++) step();
        req_v = '0;
        wait_idle(80);
        if (gnt_log.size() < 5) timeout("held_grants");
        else begin
            for (int i = 0; i < 5; i++) begin
`ifdef BRAM_RD_SCHED_PRIO_EN
                chk("held_order", gnt_log[i], 0);
`else
                chk("held_order", gnt_log[i], i % NREQ);
`endif
                if (i > 0) chk("held_gap", gnt_cyc[i] - gnt_cyc[i-1], BEATS + 1);
            end
        end

        // m_r low for five cycles at offset 3.
        req_ch[0] = 1'b1; req_st[3:0] = 4'd9; req_cl[3:0] = 4'd12;
        req_v = 4'b0001;
        wait_grant(30, got);
        req_v = '0;
        i0 = iss_cnt;
        repeat (3) step();
        m_r = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_m_v", m_v, 1);
            chk("stall_of", m_ra_of, 3);
            chk("stall_st", m_ra_st, 9);
            chk("stall_cl", m_ra_cl, 12);
            chk("stall_ch", m_ra_ch, 1);
            step();
        end
        chk("stall_no_push", iss_cnt - i0, 3);
        m_r = 1'b1;
        @(negedge clk);
        chk("resume_of", m_ra_of, 3);
        wait_idle(80);

        // Returns stalled: tag FIFO fills, then one issue per pop.
        auto_sv = 0; s_v = 1'b0;
        i0 = iss_cnt;
        req_v = 4'b0011;
        wait_grant(30, got);
        req_v = req_v & ~got;
        wait_grant(40, got);
        req_v = req_v & ~got;
        repeat (10) step();
        @(negedge clk);
        chk("full_issues", iss_cnt - i0, TAG_DEPTH);
        chk("full_m_v", m_v, 0);
        step();
        s_v = 1'b1; s_rd = 128'h1234;
        step();
        s_v = 1'b0;
        repeat (4) step();
        chk("pop_resume", iss_cnt - i0, TAG_DEPTH + 1);
        auto_sv = 1;
        wait_idle(120);

        // Owner not ready: beat held at the head.
        auto_sv = 0; s_v = 1'b0; rsp_r = 4'b1101;
        req_v = 4'b0010;
        wait_grant(30, got);
        req_v = '0;
        step();
        s_v = 1'b1; s_rd = 128'hdead_beef_0123_4567_89ab_cdef_0f0f_f0f0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("hold_s_r", s_r, 0);
            chk("hold_rsp_v", rsp_v, 4'b0010);
            chk("hold_rsp_d", rsp_d, 128'hdead_beef_0123_4567_89ab_cdef_0f0f_f0f0);
            step();
        end
        rsp_r = '1; auto_sv = 1;
        wait_idle(120);

        // Random traffic against the model.
        sv_pct = 60;
        for (int c = 0; c < 3000; c++) begin
            step();
            m_r   = ($urandom_range(9) < 7);
            rsp_r = NREQ'($urandom);
            if (gnt_flag) begin
                req_v = req_v & ~gnt_act;
                gnt_flag = 0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (!req_v[i] && $urandom_range(3) == 0) begin
                    req_ch[i*CHW +: CHW] = CHW'($urandom);
                    req_st[i*STW +: STW] = STW'($urandom);
                    req_cl[i*CLW +: CLW] = CLW'($urandom);
                    req_v[i] = 1'b1;
                end
            end
        end
        req_v = '0; m_r = 1'b1; rsp_r = '1; sv_pct = 100;
        wait_idle(400);
        chk("rand_err_clear", err, 0);

        // Reset in the middle of a burst, then a stray return.
        req_v = 4'b0001;
        wait_grant(30, got);
        req_v = '0;
        repeat (4) step();
        @(negedge clk);
        chk("pre_rst_of", m_ra_of, 4);
        step();
        reset_n = 1'b0;
        step();
        @(negedge clk);
        chk("rst_mid_req_r", req_r, 0);
        chk("rst_mid_m_v", m_v, 0);
        chk("rst_mid_rsp_v", rsp_v, 0);
        chk("rst_mid_s_r", s_r, 0);
        chk("rst_mid_err", err, 0);
        auto_sv = 0; s_v = 1'b0;
        reset_n = 1'b1;
        step();
        s_v = 1'b1;
        step();
        s_v = 1'b0;
        @(negedge clk);
        chk("stray_err", err, 1);
        repeat (3) step();
        @(negedge clk);
        chk("err_sticky", err, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
